// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   Instruction fetch initiator. Drives the instruction memory read address
//   from the fetch PC and captures the returned word. Each {pc, instruction}
//   pair goes into a small circular prefetch queue, and decode takes pairs
//   from the head over a valid/ready handshake. A redirect flushes the queue
//   and re-targets the fetch PC.
//
// Parameters
//   DEPTH     queue entries (power of two, >= 2)
//   RESET_PC  fetch PC after reset (word aligned)
//
// Ports
//   clk             clock, rising edge
//   reset           asynchronous, active-low reset
//   imem_addr       byte address to instruction memory (= fetch PC)
//   imem_dout       instruction word at imem_addr, same cycle
//   fetch_en        permits enqueueing new fetches
//   redirect_valid  flush queue and load redirect_pc
//   redirect_pc     new fetch byte address, low two bits ignored
//   deq_valid       head entry present (masked during redirect)
//   deq_ready       consumer accepts head this cycle
//   deq_inst        head instruction, 0 when empty
//   deq_pc          head PC, 0 when empty
//   count           queue occupancy, 0..DEPTH
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [31:0]                imem_addr,
    input  logic [31:0]                imem_dout,
    input  logic                       fetch_en,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [31:0]                deq_inst,
    output logic [31:0]                deq_pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [63:0]   buf_q [DEPTH];

    logic          not_empty;
    logic          deq;
    logic          enq;
    logic [63:0]   head;

    assign not_empty = (count_q != '0);
    assign deq_valid = not_empty & ~redirect_valid;
    assign deq       = deq_valid & deq_ready;
    // A full queue may still accept a fetch when the head leaves in the same cycle.
    assign enq       = fetch_en & ~redirect_valid & ((count_q != FULL_COUNT) | deq);

    assign head      = buf_q[rd_ptr];
    assign deq_pc    = not_empty ? head[63:32] : 32'h0;
    assign deq_inst  = not_empty ? head[31:0]  : 32'h0;
    assign imem_addr = fetch_pc;
    assign count     = count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
        end else begin
            if (enq) begin
                wr_ptr   <= wr_ptr + AW'(1);
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the head outputs are gated by occupancy.
    always_ff @(posedge clk) begin
        if (enq) begin
            buf_q[wr_ptr] <= {fetch_pc, imem_dout};
        end
    end

endmodule
